// File: rtl/alu_defs_pkg.sv
// Shared definitions for the ALU issue controller: opcodes, flag bit positions,
// FSM state encoding and the instruction word layout.
package alu_defs;

  localparam logic [3:0] OP_ILL0 = 4'b0000;
  localparam logic [3:0] OP_ADD  = 4'b0001;
  localparam logic [3:0] OP_SUB  = 4'b0010;
  localparam logic [3:0] OP_LDI  = 4'b0011;
  localparam logic [3:0] OP_ILL4 = 4'b0100;
  localparam logic [3:0] OP_SHL  = 4'b0101;
  localparam logic [3:0] OP_SHAR = 4'b0110;
  localparam logic [3:0] OP_SHLR = 4'b0111;
  localparam logic [3:0] OP_RL   = 4'b1000;
  localparam logic [3:0] OP_RR   = 4'b1001;
  localparam logic [3:0] OP_CMP  = 4'b1010;
  localparam logic [3:0] OP_AND  = 4'b1011;
  localparam logic [3:0] OP_OR   = 4'b1100;
  localparam logic [3:0] OP_XOR  = 4'b1101;
  localparam logic [3:0] OP_NOT  = 4'b1110;
  localparam logic [3:0] OP_MUL  = 4'b1111;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_EXEC = 1'b1;

  typedef struct packed {
    logic [3:0] opcode;
    logic [3:0] rd;
    logic [3:0] rs;
    logic [3:0] rt;
  } instr_t;

  // Opcodes that need an EXEC cycle through the external ALU (CMP included).
  function automatic logic is_alu_op(input logic [3:0] op);
    case (op)
      OP_ADD, OP_SUB, OP_SHL, OP_SHAR, OP_SHLR, OP_RL, OP_RR,
      OP_CMP, OP_AND, OP_OR, OP_XOR, OP_NOT, OP_MUL: is_alu_op = 1'b1;
      default:                                        is_alu_op = 1'b0;
    endcase
  endfunction

  function automatic logic is_illegal_op(input logic [3:0] op);
    is_illegal_op = (op == OP_ILL0) || (op == OP_ILL4);
  endfunction

endpackage

// File: rtl/alu_regfile.sv
// Register file: R0 reads as zero, two read ports captured on an enable,
// one write port and a combinational debug read port.
module alu_regfile #(
  parameter int DATA_W = 16,
  parameter int NREGS  = 16,
  parameter int AW     = $clog2(NREGS)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              rd_en,
  input  logic [AW-1:0]     ra_addr,
  input  logic [AW-1:0]     rb_addr,
  output logic [DATA_W-1:0] ra_data,
  output logic [DATA_W-1:0] rb_data,
  input  logic              we,
  input  logic [AW-1:0]     wa_addr,
  input  logic [DATA_W-1:0] wa_data,
  input  logic [AW-1:0]     dbg_addr,
  output logic [DATA_W-1:0] dbg_data
);

  logic [DATA_W-1:0] mem [NREGS];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NREGS; i++) mem[i] <= '0;
      ra_data <= '0;
      rb_data <= '0;
    end else begin
      // R0 is never written, so it stays at its reset value of zero.
      if (we && (wa_addr != '0)) mem[wa_addr] <= wa_data;
      if (rd_en) begin
        ra_data <= mem[ra_addr];
        rb_data <= mem[rb_addr];
      end
    end
  end

  assign dbg_data = mem[dbg_addr];

endmodule

// File: rtl/alu_issue_ctrl.sv
// Issue controller for the external 16-bit ALU: decodes instruction words,
// drives the ALU from latched operands and writes results and flags back.
//
// state | meaning
// IDLE  | ready for an instruction; LDI and illegal opcodes finish here
// EXEC  | ALU driven from latched operands; result and flags captured at end
module alu_issue_ctrl
  import alu_defs::*;
#(
  parameter int DATA_W = 16,
  parameter int NREGS  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              instr_valid,
  output logic              instr_ready,
  input  logic [15:0]       instr,
  output logic [3:0]        alu_op,
  output logic              alu_sub,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  input  logic [DATA_W-1:0] alu_result,
  input  logic [3:0]        alu_cc,
  output logic [3:0]        flags,
  output logic              wb_valid,
  output logic [3:0]        wb_addr,
  output logic [DATA_W-1:0] wb_data,
  output logic              illegal,
  input  logic [3:0]        dbg_addr,
  output logic [DATA_W-1:0] dbg_data
);

  logic [0:0]        state;
  instr_t            ins;
  logic              accept, acc_alu, acc_ldi, acc_ill;
  logic [3:0]        rd_q;
  logic              cmp_q;
  logic              rf_we;
  logic [3:0]        rf_waddr;
  logic [DATA_W-1:0] rf_wdata;
  logic [DATA_W-1:0] ldi_value;

  assign ins         = instr;
  assign instr_ready = (state == ST_IDLE);
  assign accept      = instr_valid && instr_ready;
  assign acc_alu     = accept && is_alu_op(ins.opcode);
  assign acc_ldi     = accept && (ins.opcode == OP_LDI);
  assign acc_ill     = accept && is_illegal_op(ins.opcode);
  assign ldi_value   = {{(DATA_W-8){1'b0}}, instr[7:0]};

  // LDI writes during its accept cycle; everything else writes at the end of EXEC.
  assign rf_we    = acc_ldi || ((state == ST_EXEC) && !cmp_q);
  assign rf_waddr = acc_ldi ? ins.rd : rd_q;
  assign rf_wdata = acc_ldi ? ldi_value : alu_result;

  alu_regfile #(.DATA_W(DATA_W), .NREGS(NREGS)) u_regfile (
    .clk      (clk),
    .reset    (reset),
    .rd_en    (acc_alu),
    .ra_addr  (ins.rs),
    .rb_addr  (ins.rt),
    .ra_data  (alu_a),
    .rb_data  (alu_b),
    .we       (rf_we),
    .wa_addr  (rf_waddr),
    .wa_data  (rf_wdata),
    .dbg_addr (dbg_addr),
    .dbg_data (dbg_data)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= ST_IDLE;
      alu_op   <= 4'b0000;
      alu_sub  <= 1'b0;
      rd_q     <= 4'd0;
      cmp_q    <= 1'b0;
      flags    <= 4'b0000;
      wb_valid <= 1'b0;
      wb_addr  <= 4'd0;
      wb_data  <= '0;
      illegal  <= 1'b0;
    end else begin
      wb_valid <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (acc_alu) begin
            state   <= ST_EXEC;
            // CMP reuses the ALU subtract path and only keeps the flags.
            alu_op  <= (ins.opcode == OP_CMP) ? OP_SUB : ins.opcode;
            alu_sub <= (ins.opcode == OP_SUB) || (ins.opcode == OP_CMP);
            rd_q    <= ins.rd;
            cmp_q   <= (ins.opcode == OP_CMP);
          end
          if (acc_ldi) begin
            wb_valid <= 1'b1;
            wb_addr  <= ins.rd;
            wb_data  <= ldi_value;
          end
          if (acc_ill) illegal <= 1'b1;
        end
        ST_EXEC: begin
          state <= ST_IDLE;
          flags <= {alu_cc[FLAG_N], alu_cc[FLAG_Z], alu_cc[FLAG_C], alu_cc[FLAG_V]};
          if (!cmp_q) begin
            wb_valid <= 1'b1;
            wb_addr  <= rd_q;
            wb_data  <= alu_result;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Directed bench for alu_issue_ctrl with a small behavioural ALU beside it.
module tb_alu_issue_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        instr_valid;
  logic        instr_ready;
  logic [15:0] instr;
  logic [3:0]  alu_op;
  logic        alu_sub;
  logic [15:0] alu_a, alu_b;
  logic [15:0] alu_result;
  logic [3:0]  alu_cc;
  logic [3:0]  flags;
  logic        wb_valid;
  logic [3:0]  wb_addr;
  logic [15:0] wb_data;
  logic        illegal;
  logic [3:0]  dbg_addr;
  logic [15:0] dbg_data;

  int errors = 0;
  int checks = 0;

  alu_issue_ctrl dut (
    .clk(clk), .reset(reset), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr(instr), .alu_op(alu_op), .alu_sub(alu_sub), .alu_a(alu_a), .alu_b(alu_b),
    .alu_result(alu_result), .alu_cc(alu_cc), .flags(flags), .wb_valid(wb_valid),
    .wb_addr(wb_addr), .wb_data(wb_data), .illegal(illegal), .dbg_addr(dbg_addr),
    .dbg_data(dbg_data)
  );

  always #5 clk = ~clk;

  // Behavioural ALU: enough operations for the directed vectors below.
  logic [16:0] sum17;
  logic [15:0] bb;
  always_comb begin
    bb         = alu_sub ? ~alu_b : alu_b;
    sum17      = {1'b0, alu_a} + {1'b0, bb} + {16'd0, alu_sub};
    alu_result = alu_a;
    alu_cc     = 4'b0000;
    case (alu_op)
      4'b0001, 4'b0010: begin
        alu_result = sum17[15:0];
        alu_cc[1]  = sum17[16];
        alu_cc[0]  = (alu_a[15] == bb[15]) && (sum17[15] != alu_a[15]);
      end
      4'b0101: alu_result = alu_a << alu_b[3:0];
      4'b1011: alu_result = alu_a & alu_b;
      4'b1100: alu_result = alu_a | alu_b;
      4'b1101: alu_result = alu_a ^ alu_b;
      4'b1110: alu_result = ~alu_b;
      default: alu_result = alu_a;
    endcase
    alu_cc[3] = alu_result[15];
    alu_cc[2] = (alu_result == 16'd0);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Presents one word; returns #1 after the accepting edge with instr_valid low.
  task automatic issue(input logic [15:0] w);
    int n = 0;
    instr       = w;
    instr_valid = 1'b1;
    while (!instr_ready && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    if (n == 20) chk("ready_timeout", 0, 1);
    @(posedge clk); #1;
    instr_valid = 1'b0;
  endtask

  task automatic next_cycle;
    @(posedge clk); #1;
  endtask

  task automatic chk_reg(input string tag, input logic [3:0] a, input logic [15:0] exp);
    dbg_addr = a;
    #1;
    chk(tag, dbg_data, exp);
  endtask

  initial begin
    reset = 1'b1; instr_valid = 1'b0; instr = 16'h0000; dbg_addr = 4'd0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready", instr_ready, 1);
    chk("rst_flags", flags, 4'h0);
    chk("rst_illegal", illegal, 0);
    chk("rst_wb_valid", wb_valid, 0);
    chk("rst_alu_op", alu_op, 4'h0);
    chk("rst_alu_a", alu_a, 16'h0);
    chk_reg("rst_r5", 4'd5, 16'h0000);
    reset = 1'b0;

    // LDI r1,5 / LDI r2,3: writeback visible one cycle after accept
    issue(16'h3105);
    chk("ldi1_wb_valid", wb_valid, 1);
    chk("ldi1_wb_addr", wb_addr, 4'd1);
    chk("ldi1_wb_data", wb_data, 16'h0005);
    chk("ldi1_ready", instr_ready, 1);
    issue(16'h3203);
    chk("ldi2_wb_data", wb_data, 16'h0003);
    chk_reg("ldi_r1", 4'd1, 16'h0005);

    // ADD r3,r1,r2
    issue(16'h1312);
    chk("add_exec_ready", instr_ready, 0);
    chk("add_exec_wb", wb_valid, 0);
    chk("add_alu_op", alu_op, 4'h1);
    chk("add_alu_sub", alu_sub, 0);
    chk("add_alu_a", alu_a, 16'h0005);
    chk("add_alu_b", alu_b, 16'h0003);
    next_cycle();
    chk("add_wb_valid", wb_valid, 1);
    chk("add_wb_addr", wb_addr, 4'd3);
    chk("add_wb_data", wb_data, 16'h0008);
    chk("add_flags", flags, 4'b0000);
    chk_reg("add_r3", 4'd3, 16'h0008);
    next_cycle();
    chk("wb_pulse_one_cycle", wb_valid, 0);

    // SUB r4,r2,r1 -> 3-5
    issue(16'h2421);
    chk("sub_alu_op", alu_op, 4'h2);
    chk("sub_alu_sub", alu_sub, 1);
    next_cycle();
    chk("sub_wb_data", wb_data, 16'hFFFE);
    chk("sub_flags", flags, 4'b1000);
    chk_reg("sub_r4", 4'd4, 16'hFFFE);

    // CMP r1,r1: flags only
    issue(16'hA011);
    chk("cmp_alu_op", alu_op, 4'h2);
    chk("cmp_alu_sub", alu_sub, 1);
    next_cycle();
    chk("cmp_wb_valid", wb_valid, 0);
    chk("cmp_flag_z", flags[2], 1);
    chk("cmp_flags", flags, 4'b0110);
    chk_reg("cmp_r1", 4'd1, 16'h0005);
    chk_reg("cmp_r2", 4'd2, 16'h0003);
    chk_reg("cmp_r3", 4'd3, 16'h0008);
    chk_reg("cmp_r4", 4'd4, 16'hFFFE);

    // Illegal opcode 0100, then three legal instructions
    issue(16'h4123);
    chk("ill_flag", illegal, 1);
    chk("ill_wb_valid", wb_valid, 0);
    chk("ill_ready", instr_ready, 1);
    chk("ill_flags_kept", flags, 4'b0110);
    chk_reg("ill_r1", 4'd1, 16'h0005);
    issue(16'h367F);
    chk("ldi6_wb_data", wb_data, 16'h007F);
    issue(16'hB712);
    next_cycle();
    chk("and_wb_data", wb_data, 16'h0001);
    issue(16'hD812);
    next_cycle();
    chk("xor_wb_data", wb_data, 16'h0006);
    chk("ill_sticky", illegal, 1);
    chk_reg("r6", 4'd6, 16'h007F);
    chk_reg("r7", 4'd7, 16'h0001);
    issue(16'hE901);
    next_cycle();
    chk("not_wb_data", wb_data, 16'hFFFA);
    chk("not_flags", flags, 4'b1000);

    // ADD r0,r1,r2 with instr_valid held high
    instr = 16'h1012; instr_valid = 1'b1;
    chk("hold_ready0", instr_ready, 1);
    next_cycle();
    chk("hold_ready1", instr_ready, 0);
    next_cycle();
    instr_valid = 1'b0;
    chk("hold_ready2", instr_ready, 1);
    chk("r0_wb_valid", wb_valid, 1);
    chk("r0_wb_addr", wb_addr, 4'd0);
    chk("r0_wb_data", wb_data, 16'h0008);
    chk_reg("r0_read", 4'd0, 16'h0000);
    next_cycle();

    // Reset during EXEC of ADD r5,r1,r2
    issue(16'h1512);
    chk("rexec_ready", instr_ready, 0);
    reset = 1'b1;
    next_cycle();
    reset = 1'b0;
    chk("rexec_wb_valid", wb_valid, 0);
    chk("rexec_ready_after", instr_ready, 1);
    chk("rexec_illegal", illegal, 0);
    chk_reg("rexec_r5", 4'd5, 16'h0000);
    next_cycle();
    chk("rexec_wb_later", wb_valid, 0);
    chk_reg("rexec_r5_later", 4'd5, 16'h0000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
